// File: rtl/cmac_ctrl_regs.sv
// cmac_ctrl_regs: toggle-handshaked GPIO command/status block for N_CH CMAC channels.
// Commands are detected on a flip of the synced gpio_o[31] and take effect on the following cycle.
module cmac_ctrl_regs #(
    parameter int N_CH          = 2,
    parameter int RST_PULSE_CYC = 16,
    parameter int CNT_W         = 12,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              init_clk,
    input  logic              sys_rstn,
    input  logic [31:0]       gpio_o,
    output logic [31:0]       gpio_i,
    input  logic [N_CH*7-1:0] st_in,
    output logic [N_CH-1:0]   loopback_en,
    output logic [N_CH-1:0]   send_continuous_pkts,
    output logic [N_CH-1:0]   sys_reset,
    output logic [N_CH-1:0]   lbus_tx_rx_restart_in
);
    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int PW = $clog2(RST_PULSE_CYC + 1);

    logic [13:0]       g_pipe [SYNC_STAGES];
    logic [N_CH*7-1:0] s_pipe [SYNC_STAGES];
    logic [13:0]       g_s;
    logic [N_CH*7-1:0] st_s, st_q;
    logic              last_tog, err, det, valid, unused_ok;
    logic [SW-1:0]     sel;
    logic [7:0]        f_ch;
    logic [2:0]        f_op;
    logic [1:0]        f_d;
    logic [6:0]        st_ch  [N_CH];
    logic [2:0]        stk_ch [N_CH];
    logic [11:0]       cnt_ch [N_CH];

    // only toggle, ch_sel, op and data bits are synchronised
    assign unused_ok = ^{gpio_o[30:20], gpio_o[11], gpio_o[7:2]};
    assign g_s  = g_pipe[SYNC_STAGES-1];
    assign st_s = s_pipe[SYNC_STAGES-1];
    assign {f_ch, f_op, f_d} = g_s[12:0];
    assign det   = g_s[13] ^ last_tog;
    assign valid = det && 32'(f_ch) < N_CH && f_op < 3'd6;

    always_ff @(posedge init_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                g_pipe[i] <= '0;
                s_pipe[i] <= '0;
            end
        end else begin
            g_pipe[0] <= {gpio_o[31], gpio_o[19:12], gpio_o[10:8], gpio_o[1:0]};
            s_pipe[0] <= st_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                g_pipe[i] <= g_pipe[i-1];
                s_pipe[i] <= s_pipe[i-1];
            end
        end
    end

    always_ff @(posedge init_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            last_tog <= 1'b0;
            err      <= 1'b0;
            sel      <= '0;
            st_q     <= '0;
            gpio_i   <= '0;
        end else begin
            st_q   <= st_s;
            gpio_i <= {last_tog, err, 6'd0, cnt_ch[sel], 1'b0, sys_reset[sel], stk_ch[sel], st_ch[sel]};
            if (det) begin
                last_tog <= g_s[13];
                err      <= !valid;
                if (valid) sel <= f_ch[SW-1:0];
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic             hit, lb, sc, rs, done_rise;
        logic [PW-1:0]    rst_cnt;
        logic [2:0]       stk, ev;
        logic [CNT_W-1:0] cnt;
        logic [6:0]       cur, prv;

        assign hit = valid && f_ch == 8'(k);
        assign cur = st_s[7*k +: 7];
        assign prv = st_q[7*k +: 7];
        // {lock_lost, align_lost, data_fail}
        assign ev        = {prv[0] & ~cur[0], prv[1] & ~cur[1], cur[4] & ~prv[4]};
        assign done_rise = cur[3] & ~prv[3];

        always_ff @(posedge init_clk or negedge sys_rstn) begin
            if (!sys_rstn) begin
                lb      <= 1'b0;
                sc      <= 1'b0;
                rs      <= 1'b0;
                rst_cnt <= '0;
                stk     <= '0;
                cnt     <= '0;
            end else begin
                rs <= hit && f_op == 3'd2;
                if (hit && f_op == 3'd0) begin
                    lb <= f_d[0];
                    sc <= f_d[1];
                end else if (hit && f_op == 3'd1) begin
                    sc <= 1'b0;
                end
                rst_cnt <= (hit && f_op == 3'd1) ? PW'(RST_PULSE_CYC) : rst_cnt - PW'(rst_cnt != '0);
                stk     <= ((hit && f_op == 3'd3) ? 3'b000 : stk) | ev;
                cnt     <= (hit && f_op == 3'd4) ? CNT_W'(done_rise) : cnt + CNT_W'(done_rise && !(&cnt));
            end
        end

        assign loopback_en[k]           = lb;
        assign send_continuous_pkts[k]  = sc;
        assign lbus_tx_rx_restart_in[k] = rs;
        assign sys_reset[k]             = rst_cnt != '0;
        assign st_ch[k]                 = cur;
        assign stk_ch[k]                = stk;
        assign cnt_ch[k]                = 12'(cnt);
    end
endmodule

// File: tb/tb_cmac_ctrl_regs.sv
// tb_cmac_ctrl_regs: randomized self-checking bench for cmac_ctrl_regs against a command-level model.
module tb_cmac_ctrl_regs;
    localparam int N_CH = 2, RPC = 16, CW = 4;

    logic              init_clk = 1'b0, sys_rstn = 1'b0, tog = 1'b0, m_err = 1'b0;
    logic [31:0]       gpio_o = '0, gpio_i;
    logic [N_CH*7-1:0] st_in = '0;
    logic [N_CH-1:0]   loopback_en, send_continuous_pkts, sys_reset, lbus_tx_rx_restart_in;
    logic [N_CH-1:0]   m_lb = '0, m_sc = '0;
    logic [2:0]        m_stk [N_CH];
    int                m_cnt [N_CH];
    int                m_sel = 0, checks = 0, errors = 0;

    cmac_ctrl_regs #(.N_CH(N_CH), .RST_PULSE_CYC(RPC), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .init_clk(init_clk), .sys_rstn(sys_rstn), .gpio_o(gpio_o), .gpio_i(gpio_i), .st_in(st_in),
        .loopback_en(loopback_en), .send_continuous_pkts(send_continuous_pkts),
        .sys_reset(sys_reset), .lbus_tx_rx_restart_in(lbus_tx_rx_restart_in));

    always #5 init_clk = ~init_clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge init_clk);
    endtask

    task automatic model_reset();
        tog = 1'b0; m_err = 1'b0; m_sel = 0; m_lb = '0; m_sc = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_stk[c] = '0;
            m_cnt[c] = 0;
        end
    endtask

    task automatic apply(input int ch, input int op, input logic [1:0] d);
        if (ch >= N_CH || op > 5) begin
            m_err = 1'b1;
            return;
        end
        m_sel = ch; m_err = 1'b0;
        if (op == 0) begin m_lb[ch] = d[0]; m_sc[ch] = d[1]; end
        if (op == 1) m_sc[ch] = 1'b0;
        if (op == 3) m_stk[ch] = '0;
        if (op == 4) m_cnt[ch] = 0;
    endtask

    // writes fields, then flips the toggle one cycle later; ev_bit >= 0 raises that st_in bit together with the flip
    task automatic issue(input int ch, input int op, input logic [1:0] d, input int ev_bit);
        gpio_o = {tog, 11'd0, 8'(ch), 1'b0, 3'(op), 6'd0, d};
        cyc(1);
        tog = ~tog;
        gpio_o[31] = tog;
        if (ev_bit >= 0) st_in[ev_bit] = 1'b1;
        apply(ch, op, d);
    endtask

    task automatic pulse(input int c, input int n);
        repeat (n) begin
            st_in[7*c+3] = 1'b1;
            cyc(2);
            st_in[7*c+3] = 1'b0;
            cyc(2);
            if (m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
        end
    endtask

    function automatic logic [31:0] exp_gpio();
        logic [6:0] s;
        s = st_in[m_sel*7 +: 7];
        return {tog, m_err, 6'd0, 12'(m_cnt[m_sel]), 1'b0, 1'b0, m_stk[m_sel], s};
    endfunction

    task automatic test_reset();
        model_reset();
        cyc(3);
        checks += 3;
        if (gpio_i !== 32'h0) begin errors++; $display("FAIL reset_gpio_i: got %h want %h", gpio_i, 32'h0); end
        if ({loopback_en, send_continuous_pkts} !== '0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {loopback_en, send_continuous_pkts}); end
        if ({sys_reset, lbus_tx_rx_restart_in} !== '0) begin errors++; $display("FAIL reset_pulses: got %b want 0", {sys_reset, lbus_tx_rx_restart_in}); end
        sys_rstn = 1'b1;
        cyc(6);
        checks += 2;
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL release_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
        if ({loopback_en, send_continuous_pkts, sys_reset, lbus_tx_rx_restart_in} !== '0) begin errors++; $display("FAIL release_outputs: got %b want 0", {loopback_en, send_continuous_pkts, sys_reset, lbus_tx_rx_restart_in}); end
    endtask

    task automatic test_wr_ctrl();
        issue(1, 0, 2'b11, -1);
        cyc(3);
        checks += 3;
        if (loopback_en !== 2'b10) begin errors++; $display("FAIL wr_ctrl_lb: got %b want %b", loopback_en, 2'b10); end
        if (send_continuous_pkts !== 2'b10) begin errors++; $display("FAIL wr_ctrl_sc: got %b want %b", send_continuous_pkts, 2'b10); end
        if (gpio_i[31] !== ~tog) begin errors++; $display("FAIL wr_ctrl_early_ack: got %b want %b", gpio_i[31], ~tog); end
        cyc(1);
        checks += 2;
        if (gpio_i[31] !== tog) begin errors++; $display("FAIL wr_ctrl_ack: got %b want %b", gpio_i[31], tog); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL wr_ctrl_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
    endtask

    task automatic test_restart();
        issue(1, 2, 2'b00, -1);
        cyc(2);
        checks += 4;
        if (lbus_tx_rx_restart_in !== 2'b00) begin errors++; $display("FAIL restart_early: got %b want 00", lbus_tx_rx_restart_in); end
        cyc(1);
        if (lbus_tx_rx_restart_in !== 2'b10) begin errors++; $display("FAIL restart_pulse: got %b want 10", lbus_tx_rx_restart_in); end
        cyc(1);
        if (lbus_tx_rx_restart_in !== 2'b00) begin errors++; $display("FAIL restart_end: got %b want 00", lbus_tx_rx_restart_in); end
        if (gpio_i[31] !== tog) begin errors++; $display("FAIL restart_ack: got %b want %b", gpio_i[31], tog); end
    endtask

    task automatic test_rst_pulse();
        int hi0, hi1;
        issue(0, 0, 2'b10, -1);
        cyc(4);
        checks++;
        if (send_continuous_pkts !== m_sc) begin errors++; $display("FAIL rst_pre_sc: got %b want %b", send_continuous_pkts, m_sc); end
        hi0 = 0; hi1 = 0;
        issue(0, 1, 2'b00, -1);
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            hi0 += int'(sys_reset[0]);
            hi1 += int'(sys_reset[1]);
        end
        checks += 3;
        if (hi0 != RPC) begin errors++; $display("FAIL rst_len: got %0d want %0d", hi0, RPC); end
        if (hi1 != 0) begin errors++; $display("FAIL rst_other_ch: got %0d want 0", hi1); end
        if (send_continuous_pkts !== m_sc) begin errors++; $display("FAIL rst_sc_forced: got %b want %b", send_continuous_pkts, m_sc); end
        hi0 = 0;
        issue(0, 1, 2'b00, -1);
        for (int i = 1; i <= 50; i++) begin
            cyc(1);
            hi0 += int'(sys_reset[0]);
            if (i == 10) begin
                tog = ~tog;
                gpio_o[31] = tog;
                apply(0, 1, 2'b00);
            end
        end
        checks++;
        if (hi0 != 10 + RPC) begin errors++; $display("FAIL rst_reissue_len: got %0d want %0d", hi0, 10 + RPC); end
    endtask

    task automatic test_invalid();
        issue(5, 0, 2'b11, -1);
        cyc(4);
        checks += 4;
        if ({loopback_en, send_continuous_pkts} !== {m_lb, m_sc}) begin errors++; $display("FAIL inv_outputs: got %b want %b", {loopback_en, send_continuous_pkts}, {m_lb, m_sc}); end
        if (gpio_i[30] !== 1'b1) begin errors++; $display("FAIL inv_err: got %b want 1", gpio_i[30]); end
        if (gpio_i[31] !== tog) begin errors++; $display("FAIL inv_ack: got %b want %b", gpio_i[31], tog); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL inv_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
        issue(0, 6, 2'b11, -1);
        cyc(4);
        checks++;
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL inv_op6: got %h want %h", gpio_i, exp_gpio()); end
        issue(0, 5, 2'b00, -1);
        cyc(4);
        checks += 2;
        if (gpio_i[30] !== 1'b0) begin errors++; $display("FAIL inv_clear_err: got %b want 0", gpio_i[30]); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL inv_sel: got %h want %h", gpio_i, exp_gpio()); end
    endtask

    task automatic test_sticky_cnt();
        st_in = {7'b0000011, 7'b0000011};
        cyc(6);
        pulse(1, 3);
        st_in[7+1] = 1'b0;
        m_stk[1][1] = 1'b1;
        cyc(4);
        issue(1, 5, 2'b00, -1);
        cyc(4);
        checks += 3;
        if (gpio_i[23:12] !== 12'(m_cnt[1])) begin errors++; $display("FAIL cnt_ch1: got %0d want %0d", gpio_i[23:12], m_cnt[1]); end
        if (gpio_i[8] !== 1'b1) begin errors++; $display("FAIL align_lost: got %b want 1", gpio_i[8]); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL sticky_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
        issue(0, 5, 2'b00, -1);
        cyc(4);
        checks++;
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL ch0_isolated: got %h want %h", gpio_i, exp_gpio()); end
        issue(1, 3, 2'b00, 7 + 4);
        m_stk[1][0] = 1'b1;
        cyc(6);
        checks += 2;
        if (gpio_i[9:7] !== 3'b001) begin errors++; $display("FAIL clr_vs_set: got %b want 001", gpio_i[9:7]); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL clr_sticky_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
    endtask

    task automatic test_saturation();
        issue(0, 5, 2'b00, -1);
        pulse(0, 17 + int'($urandom_range(0, 8)));
        cyc(2);
        checks += 2;
        if (gpio_i[23:12] !== 12'(m_cnt[0])) begin errors++; $display("FAIL sat_cnt: got %0d want %0d", gpio_i[23:12], m_cnt[0]); end
        if (m_cnt[0] != (1 << CW) - 1) begin errors++; $display("FAIL sat_model: got %0d want %0d", m_cnt[0], (1 << CW) - 1); end
        issue(0, 4, 2'b00, 3);
        m_cnt[0] = 1;
        cyc(2);
        st_in[3] = 1'b0;
        cyc(4);
        checks += 2;
        if (gpio_i[23:12] !== 12'd1) begin errors++; $display("FAIL clr_cnt_vs_edge: got %0d want 1", gpio_i[23:12]); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL clr_cnt_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
    endtask

    task automatic test_random();
        int ch, op;
        logic [1:0] d;
        for (int n = 0; n < 30; n++) begin
            pulse(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 3)));
            ch = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 7));
            if (op == 1) op = 5;
            d = 2'($urandom_range(0, 3));
            issue(ch, op, d, -1);
            cyc(4);
            checks += 2;
            if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL rand_gpio_i[%0d] ch=%0d op=%0d: got %h want %h", n, ch, op, gpio_i, exp_gpio()); end
            if ({loopback_en, send_continuous_pkts} !== {m_lb, m_sc}) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", n, {loopback_en, send_continuous_pkts}, {m_lb, m_sc}); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int hi;
        issue(1, 1, 2'b00, -1);
        cyc(5);
        checks++;
        if (sys_reset[1] !== 1'b1) begin errors++; $display("FAIL mid_pulse_active: got %b want 1", sys_reset[1]); end
        #2;
        sys_rstn = 1'b0;
        gpio_o = '0;
        st_in = '0;
        model_reset();
        #1;
        checks += 2;
        if (sys_reset !== '0) begin errors++; $display("FAIL async_rst_pulse: got %b want 0", sys_reset); end
        if (gpio_i !== 32'h0) begin errors++; $display("FAIL async_rst_gpio_i: got %h want 0", gpio_i); end
        cyc(2);
        sys_rstn = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            hi += int'(sys_reset != '0);
        end
        checks += 2;
        if (hi != 0) begin errors++; $display("FAIL pulse_resumed: got %0d want 0", hi); end
        if (gpio_i !== exp_gpio()) begin errors++; $display("FAIL post_rst_gpio_i: got %h want %h", gpio_i, exp_gpio()); end
    endtask

    initial begin
        test_reset();
        test_wr_ctrl();
        test_restart();
        test_rst_pulse();
        test_invalid();
        test_sticky_cnt();
        test_saturation();
        test_random();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
